// File: rtl/id_ex_stage_reg_pkg.sv
// Shared ID/EX definitions: default widths, the decoder control-word bit map (also used by the
// decoder packer), and instruction register-field positions.
package id_ex_stage_reg_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int CTRL_W_DEF = 19;
  localparam int CNT_W_DEF  = 16;

  // Control-word bit indices; bit 18 is spare
  localparam int REG_DEST       = 0;
  localparam int BRANCH_EQ      = 1;
  localparam int BRANCH_NE      = 2;
  localparam int MEM_READ       = 3;
  localparam int MEM_TO_REG     = 4;
  localparam int ALU_OP1        = 5;
  localparam int ALU_OP2        = 6;
  localparam int MEM_WRITE      = 7;
  localparam int ALU_SRC        = 8;
  localparam int REG_WRITE      = 9;
  localparam int JUMP           = 10;
  localparam int TRUNK_MODE_LO  = 11;
  localparam int TRUNK_MODE_HI  = 12;
  localparam int SHIFT_TO_TRUNK = 13;
  localparam int SIN_SIGNO      = 14;
  localparam int J_REG          = 15;
  localparam int SAVE_PC        = 16;
  localparam int I_TYPE         = 17;

  localparam int RS_LSB = 21;
  localparam int RT_LSB = 16;

  typedef logic [4:0] regIdx_t;

  function automatic logic [CTRL_W_DEF-1:0] ctrlMask(input int idx);
    return CTRL_W_DEF'(1) << idx;
  endfunction

endpackage

// File: rtl/id_ex_stage_reg_if.sv
// ID/EX boundary bundle: ID-side operands and stage controls in, registered EX copies and
// stall enables out.
interface id_ex_stage_reg_if
  import id_ex_stage_reg_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int CTRL_W = CTRL_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) ();

  logic [CTRL_W-1:0] id_ctrl;
  logic [DATA_W-1:0] id_pc4;
  logic [DATA_W-1:0] id_rs_data;
  logic [DATA_W-1:0] id_rt_data;
  logic [DATA_W-1:0] id_imm;
  logic [DATA_W-1:0] id_instr;
  logic              ex_flush;
  logic              hold;

  logic [CTRL_W-1:0] ex_ctrl;
  logic [DATA_W-1:0] ex_pc4;
  logic [DATA_W-1:0] ex_rs_data;
  logic [DATA_W-1:0] ex_rt_data;
  logic [DATA_W-1:0] ex_imm;
  logic [DATA_W-1:0] ex_instr;
  logic              pc_write;
  logic              if_id_write;
  logic [CNT_W-1:0]  bubble_count;

  modport master (
    output id_ctrl, id_pc4, id_rs_data, id_rt_data, id_imm, id_instr, ex_flush, hold,
    input  ex_ctrl, ex_pc4, ex_rs_data, ex_rt_data, ex_imm, ex_instr,
           pc_write, if_id_write, bubble_count
  );

  modport slave (
    input  id_ctrl, id_pc4, id_rs_data, id_rt_data, id_imm, id_instr, ex_flush, hold,
    output ex_ctrl, ex_pc4, ex_rs_data, ex_rt_data, ex_imm, ex_instr,
           pc_write, if_id_write, bubble_count
  );

endinterface

// File: rtl/id_ex_stage_reg_load_use_detect.sv
// Load-use hazard term: the load now in EX writes a register the ID instruction reads.
module load_use_detect
  import id_ex_stage_reg_pkg::*;
#(
  parameter int CTRL_W = CTRL_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic [CTRL_W-1:0] ex_ctrl,
  input  logic [DATA_W-1:0] ex_instr,
  input  logic [CTRL_W-1:0] id_ctrl,
  input  logic [DATA_W-1:0] id_instr,
  output logic              hazard
);

  regIdx_t exDst;
  regIdx_t idRs;
  regIdx_t idRt;
  logic    exIsLoad;
  logic    usesRs;
  logic    usesRt;
  logic    unusedBits;

  assign exDst    = ex_instr[RT_LSB +: 5];
  assign idRs     = id_instr[RS_LSB +: 5];
  assign idRt     = id_instr[RT_LSB +: 5];
  assign exIsLoad = ex_ctrl[MEM_READ];

  // Direct jumps carry a target in the rs field, so only JR actually reads rs
  assign usesRs = ~(id_ctrl[JUMP] & ~id_ctrl[J_REG]);
  assign usesRt = id_ctrl[REG_DEST] | id_ctrl[BRANCH_EQ] | id_ctrl[BRANCH_NE] | id_ctrl[MEM_WRITE];

  assign hazard = exIsLoad & (exDst != 5'd0) &
                  ((usesRs & (exDst == idRs)) | (usesRt & (exDst == idRt)));

  assign unusedBits = ^{ex_ctrl, ex_instr, id_ctrl, id_instr};

endmodule

// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register with load-use bubble insertion, flush/hold handling and a
// saturating bubble counter.
module id_ex_stage_reg
  import id_ex_stage_reg_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int CTRL_W = CTRL_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic         clk,
  input  logic         reset,
  id_ex_stage_reg_if.slave bus
);

  logic [CTRL_W-1:0] ctrl_p1;
  logic [DATA_W-1:0] pc4_p1;
  logic [DATA_W-1:0] rsData_p1;
  logic [DATA_W-1:0] rtData_p1;
  logic [DATA_W-1:0] imm_p1;
  logic [DATA_W-1:0] instr_p1;
  logic [CNT_W-1:0]  bubbleCnt;
  logic              hazard;
  logic              advance;

  function automatic logic [CNT_W-1:0] satInc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  load_use_detect #(
    .CTRL_W (CTRL_W),
    .DATA_W (DATA_W)
  ) uDetect (
    .ex_ctrl  (ctrl_p1),
    .ex_instr (instr_p1),
    .id_ctrl  (bus.id_ctrl),
    .id_instr (bus.id_instr),
    .hazard   (hazard)
  );

  // A flush kills the hazarding instruction, so it never needs to stall the front end
  assign advance         = ~(bus.hold | (hazard & ~bus.ex_flush));
  assign bus.pc_write    = advance;
  assign bus.if_id_write = advance;

  // ---- ID -> EX boundary ----
  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl_p1   <= '0;
      pc4_p1    <= '0;
      rsData_p1 <= '0;
      rtData_p1 <= '0;
      imm_p1    <= '0;
      instr_p1  <= '0;
      bubbleCnt <= '0;
    end else if (bus.ex_flush || !bus.hold) begin
      pc4_p1    <= bus.id_pc4;
      rsData_p1 <= bus.id_rs_data;
      rtData_p1 <= bus.id_rt_data;
      imm_p1    <= bus.id_imm;
      instr_p1  <= bus.id_instr;
      ctrl_p1   <= (bus.ex_flush || hazard) ? '0 : bus.id_ctrl;
      if (!bus.ex_flush && hazard)
        bubbleCnt <= satInc(bubbleCnt);
    end
  end

  assign bus.ex_ctrl      = ctrl_p1;
  assign bus.ex_pc4       = pc4_p1;
  assign bus.ex_rs_data   = rsData_p1;
  assign bus.ex_rt_data   = rtData_p1;
  assign bus.ex_imm       = imm_p1;
  assign bus.ex_instr     = instr_p1;
  assign bus.bubble_count = bubbleCnt;

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Table-driven bench for id_ex_stage_reg: a 16-bit-counter instance and a 2-bit-counter
// instance see identical stimulus; expected EX state is queued per vector and checked after the edge.
module tb_id_ex_stage_reg;
  import id_ex_stage_reg_pkg::*;

  typedef struct {
    logic        rst;
    logic        flush;
    logic        hold;
    logic [18:0] ctrl;
    logic [31:0] instr;
    logic [31:0] pc4;
    logic        chkPcw;
    logic        pcw;
    logic [18:0] eCtrl;
    logic [31:0] eInstr;
    logic [31:0] ePc4;
    logic [31:0] eCnt;
  } vec_t;

  localparam logic [31:0] LW2  = 32'h8C22_0000;  // LW  $2,0($1)
  localparam logic [31:0] LW0  = 32'h8C20_0000;  // LW  $0,0($1)
  localparam logic [31:0] ADD  = 32'h0044_1820;  // ADD $3,$2,$4
  localparam logic [31:0] ADD0 = 32'h0004_1820;  // ADD $3,$0,$4
  localparam logic [31:0] JMP  = 32'h0840_0000;  // J with rs field = 2
  localparam logic [31:0] SW2  = 32'hACA2_0004;  // SW  $2,4($5)
  localparam logic [31:0] ORI2 = 32'h34A2_0001;  // ORI $2,$5,1

  logic clk = 1'b0;
  logic reset;
  int   tests = 0;
  int   fails = 0;
  vec_t vecs[$];
  vec_t sb[$];

  logic [18:0] cLw, cAdd, cJ, cSw, cOri;

  always #5 clk = ~clk;

  id_ex_stage_reg_if #(.DATA_W(32), .CTRL_W(19), .CNT_W(16)) busA ();
  id_ex_stage_reg_if #(.DATA_W(32), .CTRL_W(19), .CNT_W(2))  busB ();

  id_ex_stage_reg #(.DATA_W(32), .CTRL_W(19), .CNT_W(16)) dutA (.clk(clk), .reset(reset), .bus(busA));
  id_ex_stage_reg #(.DATA_W(32), .CTRL_W(19), .CNT_W(2))  dutB (.clk(clk), .reset(reset), .bus(busB));

  function automatic vec_t mk(input logic rst, input logic flush, input logic hold,
                              input logic [18:0] ctrl, input logic [31:0] instr, input logic [31:0] pc4,
                              input logic chkPcw, input logic pcw, input logic [18:0] eCtrl,
                              input logic [31:0] eInstr, input logic [31:0] ePc4, input logic [31:0] eCnt);
    vec_t v;
    v.rst = rst; v.flush = flush; v.hold = hold; v.ctrl = ctrl; v.instr = instr; v.pc4 = pc4;
    v.chkPcw = chkPcw; v.pcw = pcw; v.eCtrl = eCtrl; v.eInstr = eInstr; v.ePc4 = ePc4; v.eCnt = eCnt;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic applyVec(input vec_t v);
    vec_t e;
    logic [31:0] satCnt;
    @(negedge clk);
    reset = v.rst;
    busA.id_ctrl = v.ctrl;        busB.id_ctrl = v.ctrl;
    busA.id_instr = v.instr;      busB.id_instr = v.instr;
    busA.id_pc4 = v.pc4;          busB.id_pc4 = v.pc4;
    busA.id_rs_data = v.pc4 << 8; busB.id_rs_data = v.pc4 << 8;
    busA.id_rt_data = v.pc4 << 16; busB.id_rt_data = v.pc4 << 16;
    busA.id_imm = v.pc4 << 4;     busB.id_imm = v.pc4 << 4;
    busA.ex_flush = v.flush;      busB.ex_flush = v.flush;
    busA.hold = v.hold;           busB.hold = v.hold;
    sb.push_back(v);
    #1;
    if (v.chkPcw) begin
      chk("pc_write", 32'(busA.pc_write), 32'(v.pcw));
      chk("if_id_write", 32'(busA.if_id_write), 32'(v.pcw));
      chk("pc_write_cnt2", 32'(busB.pc_write), 32'(v.pcw));
    end
    @(posedge clk);
    #1;
    e = sb.pop_front();
    satCnt = (e.eCnt > 32'd3) ? 32'd3 : e.eCnt;
    chk("ex_ctrl", 32'(busA.ex_ctrl), 32'(e.eCtrl));
    chk("ex_instr", busA.ex_instr, e.eInstr);
    chk("ex_pc4", busA.ex_pc4, e.ePc4);
    chk("ex_rs_data", busA.ex_rs_data, e.ePc4 << 8);
    chk("ex_rt_data", busA.ex_rt_data, e.ePc4 << 16);
    chk("ex_imm", busA.ex_imm, e.ePc4 << 4);
    chk("bubble_count", 32'(busA.bubble_count), e.eCnt);
    chk("bubble_count_cnt2", 32'(busB.bubble_count), satCnt);
    chk("ex_ctrl_cnt2", 32'(busB.ex_ctrl), 32'(e.eCtrl));
  endtask

  initial begin
    cLw  = ctrlMask(MEM_READ) | ctrlMask(MEM_TO_REG) | ctrlMask(ALU_SRC) | ctrlMask(REG_WRITE) | ctrlMask(I_TYPE);
    cAdd = ctrlMask(REG_DEST) | ctrlMask(REG_WRITE) | ctrlMask(ALU_OP1);
    cJ   = ctrlMask(JUMP);
    cSw  = ctrlMask(MEM_WRITE) | ctrlMask(ALU_SRC) | ctrlMask(I_TYPE);
    cOri = ctrlMask(ALU_SRC) | ctrlMask(REG_WRITE) | ctrlMask(I_TYPE) | ctrlMask(ALU_OP2);

    reset = 1'b1;
    busA.id_ctrl = '0; busA.id_instr = '0; busA.id_pc4 = '0; busA.id_rs_data = '0;
    busA.id_rt_data = '0; busA.id_imm = '0; busA.ex_flush = 1'b0; busA.hold = 1'b0;
    busB.id_ctrl = '0; busB.id_instr = '0; busB.id_pc4 = '0; busB.id_rs_data = '0;
    busB.id_rt_data = '0; busB.id_imm = '0; busB.ex_flush = 1'b0; busB.hold = 1'b0;

    // reset with random ID contents
    vecs.push_back(mk(1, 0, 0, 19'($urandom), $urandom, 32'h1FC, 0, 0, '0, '0, '0, 0));
    vecs.push_back(mk(1, 0, 0, cLw, LW2, 32'h1F8, 1, 1, '0, '0, '0, 0));
    // load-use stall and release
    vecs.push_back(mk(0, 0, 0, cLw,  LW2,  32'h104, 1, 1, cLw,  LW2,  32'h104, 0));
    vecs.push_back(mk(0, 0, 0, cAdd, ADD,  32'h108, 1, 0, '0,   ADD,  32'h108, 1));
    vecs.push_back(mk(0, 0, 0, cAdd, ADD,  32'h108, 1, 1, cAdd, ADD,  32'h108, 1));
    // no false hazards: $0 destination, direct jump, rt not read
    vecs.push_back(mk(0, 0, 0, cLw,  LW0,  32'h10C, 1, 1, cLw,  LW0,  32'h10C, 1));
    vecs.push_back(mk(0, 0, 0, cAdd, ADD0, 32'h110, 1, 1, cAdd, ADD0, 32'h110, 1));
    vecs.push_back(mk(0, 0, 0, cLw,  LW2,  32'h114, 1, 1, cLw,  LW2,  32'h114, 1));
    vecs.push_back(mk(0, 0, 0, cJ,   JMP,  32'h118, 1, 1, cJ,   JMP,  32'h118, 1));
    vecs.push_back(mk(0, 0, 0, cLw,  LW2,  32'h11C, 1, 1, cLw,  LW2,  32'h11C, 1));
    vecs.push_back(mk(0, 0, 0, cSw,  SW2,  32'h120, 1, 0, '0,   SW2,  32'h120, 2));
    vecs.push_back(mk(0, 0, 0, cSw,  SW2,  32'h120, 1, 1, cSw,  SW2,  32'h120, 2));
    vecs.push_back(mk(0, 0, 0, cLw,  LW2,  32'h124, 1, 1, cLw,  LW2,  32'h124, 2));
    vecs.push_back(mk(0, 0, 0, cOri, ORI2, 32'h128, 1, 1, cOri, ORI2, 32'h128, 2));
    // flush beats hazard
    vecs.push_back(mk(0, 0, 0, cLw,  LW2,  32'h12C, 1, 1, cLw,  LW2,  32'h12C, 2));
    vecs.push_back(mk(0, 1, 0, cAdd, ADD,  32'h130, 1, 1, '0,   ADD,  32'h130, 2));
    // three-cycle hold with a pending hazard, then release
    vecs.push_back(mk(0, 0, 0, cLw,  LW2,  32'h134, 1, 1, cLw,  LW2,  32'h134, 2));
    vecs.push_back(mk(0, 0, 1, cAdd, ADD,  32'h138, 1, 0, cLw,  LW2,  32'h134, 2));
    vecs.push_back(mk(0, 0, 1, cOri, ORI2, 32'h13C, 1, 0, cLw,  LW2,  32'h134, 2));
    vecs.push_back(mk(0, 0, 1, cJ,   JMP,  32'h140, 1, 0, cLw,  LW2,  32'h134, 2));
    vecs.push_back(mk(0, 0, 0, cOri, ORI2, 32'h144, 1, 1, cOri, ORI2, 32'h144, 2));
    // flush overrides hold
    vecs.push_back(mk(0, 1, 1, cLw,  LW2,  32'h148, 1, 0, '0,   LW2,  32'h148, 2));
    vecs.push_back(mk(0, 0, 0, cAdd, ADD,  32'h14C, 1, 1, cAdd, ADD,  32'h14C, 2));
    // reset in the middle of a stall
    vecs.push_back(mk(0, 0, 0, cLw,  LW2,  32'h150, 1, 1, cLw,  LW2,  32'h150, 2));
    vecs.push_back(mk(1, 0, 0, cAdd, ADD,  32'h154, 1, 0, '0,   '0,   '0,      0));
    vecs.push_back(mk(0, 0, 1, cAdd, ADD,  32'h154, 1, 0, '0,   '0,   '0,      0));
    vecs.push_back(mk(0, 0, 0, cAdd, ADD,  32'h154, 1, 1, cAdd, ADD,  32'h154, 0));
    // five bubbles back to back: 2-bit counter must stop at 3
    for (int k = 0; k < 5; k++) begin
      vecs.push_back(mk(0, 0, 0, cLw,  LW2, 32'h200 + 32'(8 * k), 1, 1, cLw, LW2, 32'h200 + 32'(8 * k), 32'(k)));
      vecs.push_back(mk(0, 0, 0, cAdd, ADD, 32'h204 + 32'(8 * k), 1, 0, '0,  ADD, 32'h204 + 32'(8 * k), 32'(k + 1)));
    end

    foreach (vecs[i]) applyVec(vecs[i]);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
